// File: rtl/fir_hls_stream_ctrl.sv
// Stream sequencer for one ap_ctrl_hs FIR core: input sample FIFO, one call per sample,
// 1-entry result register on a valid/ready output, and a watchdog for a hung core.
module fir_hls_stream_ctrl #(
  parameter int unsigned XW         = 8,
  parameter int unsigned YW         = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          ap_clk,
  input  logic          ap_rst,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [XW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [YW-1:0] m_data,
  output logic          fir_start,
  output logic [XW-1:0] fir_x,
  input  logic          fir_done,
  input  logic          fir_idle,
  input  logic          fir_ready,
  input  logic [YW-1:0] fir_y,
  input  logic          fir_y_vld,
  output logic          busy,
  output logic          err_timeout,
  output logic [15:0]   sample_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] Full = CW'(FIFO_DEPTH);
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StErr} state_e;

  state_e        state_q, state_d;
  logic [XW-1:0] mem_q [FIFO_DEPTH];
  logic [XW-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    wdog_q, wdog_d;
  logic          s_ready_q, s_ready_d;
  logic          m_valid_q, m_valid_d;
  logic [YW-1:0] m_data_q, m_data_d;
  logic          fir_start_q, fir_start_d;
  logic [XW-1:0] fir_x_q, fir_x_d;
  logic          busy_q, busy_d;
  logic          err_q, err_d;
  logic [15:0]   sample_cnt_q, sample_cnt_d;

  logic push, pop, launch, capture;

  always_comb begin
    // s_ready_q is already low when full or in ERR, so no extra qualification is needed.
    push    = s_valid & s_ready_q;
    pop     = 1'b0;
    launch  = 1'b0;
    capture = fir_y_vld & ((state_q == StStart) | (state_q == StWait));
    state_d = state_q;
    wdog_d  = wdog_q;

    unique case (state_q)
      StIdle: begin
        if ((count_q != '0) && fir_idle && (!m_valid_q || m_ready)) begin
          state_d = StStart;
          launch  = 1'b1;
          wdog_d  = '0;
        end
      end
      StStart: begin
        wdog_d = wdog_q + 8'd1;
        if (fir_ready) begin
          pop     = 1'b1;
          state_d = fir_done ? StIdle : StWait;
        end else if (wdog_q == TimeoutLast) begin
          state_d = StErr;
        end
      end
      StWait: begin
        wdog_d = wdog_q + 8'd1;
        if (fir_done) begin
          state_d = StIdle;
        end else if (wdog_q == TimeoutLast) begin
          state_d = StErr;
        end
      end
      StErr: begin
        state_d = StErr;
      end
    endcase

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = s_data;
    end
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    s_ready_d   = (count_d != Full) && (state_d != StErr);
    fir_start_d = (state_d == StStart);
    // x is latched at launch so it stays stable for the whole START state.
    fir_x_d     = launch ? mem_q[rd_ptr_q] : fir_x_q;
    busy_d      = (state_d != StIdle);
    err_d       = (state_d == StErr);

    if (capture) begin
      m_valid_d = 1'b1;
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
    m_data_d     = capture ? fir_y : m_data_q;
    sample_cnt_d = sample_cnt_q + 16'(capture);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wdog_q       <= '0;
      s_ready_q    <= 1'b0;
      m_valid_q    <= 1'b0;
      m_data_q     <= '0;
      fir_start_q  <= 1'b0;
      fir_x_q      <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wdog_q       <= wdog_d;
      s_ready_q    <= s_ready_d;
      m_valid_q    <= m_valid_d;
      m_data_q     <= m_data_d;
      fir_start_q  <= fir_start_d;
      fir_x_q      <= fir_x_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once count_q says they were written.
  always_ff @(posedge ap_clk) begin
    mem_q <= mem_d;
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign fir_start   = fir_start_q;
  assign fir_x       = fir_x_q;
  assign busy        = busy_q;
  assign err_timeout = err_q;
  assign sample_cnt  = sample_cnt_q;

endmodule

// File: doc/fir_hls_stream_ctrl.md
Name: fir_hls_stream_ctrl

Overview:
- Sequencer that sits between a valid/ready sample stream and one fir_hls core, which uses the ap_ctrl_hs handshake.
- Buffers incoming 8-bit samples in a small FIFO, launches one FIR call per sample and holds x stable.
- Captures y on y_ap_vld into a 1-entry output register presented as a valid/ready stream.
- Watchdog flags a hung core. Instantiated alongside fir_hls in the FIR8 top and in the co-simulation bench.

Parameters:
- XW, 8, sample width (fir x).
- YW, 16, result width (fir y).
- FIFO_DEPTH, 4, input FIFO entries; power of 2, minimum 2.
- TIMEOUT, 255, max cycles spent in START+WAIT before error; 8-bit counter.

Ports:
- ap_clk  in  1  single clock.
- ap_rst  in  1  synchronous, active-high reset; the same net also resets fir_hls.
- s_valid  in  1  input sample valid.
- s_ready  out  1  FIFO can accept.
- s_data  in  XW  input sample.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts.
- m_data  out  YW  result.
- fir_start  out  1  to fir_hls ap_start.
- fir_x  out  XW  to fir_hls x.
- fir_done  in  1  from ap_done.
- fir_idle  in  1  from ap_idle.
- fir_ready  in  1  from ap_ready.
- fir_y  in  YW  from y.
- fir_y_vld  in  1  from y_ap_vld.
- busy  out  1  FSM not in IDLE.
- err_timeout  out  1  sticky watchdog error.
- sample_cnt  out  16  count of results captured; wraps 0xFFFF to 0.

Behaviour:
Reset (ap_rst=1 at a rising edge):
- FSM=IDLE, FIFO empty, watchdog counter=0.
- All outputs 0: s_ready=0 during the reset cycle, then 1; m_valid=0, m_data=0, fir_start=0, fir_x=0, busy=0, err_timeout=0, sample_cnt=0.
- Reset mid-operation discards FIFO contents, any in-flight call and the output register, with no further handshakes.

FIFO:
- Push when s_valid & s_ready; s_ready = !full. No pass-through: full with a simultaneous pop still gives s_ready=0.
- Pointers wrap modulo FIFO_DEPTH; full/empty come from a count register.

FSM (IDLE, START, WAIT, ERR):
- IDLE -> START when FIFO non-empty & fir_idle & (!m_valid | m_ready).
- START: fir_start=1; fir_x=FIFO head, stable for the whole state. fir_start is held until fir_ready is sampled 1. On that cycle pop the FIFO; fir_start drops the next cycle.
  - fir_ready & fir_done in the same cycle -> IDLE.
  - fir_ready only -> WAIT.
- WAIT: fir_start=0; fir_done -> IDLE.
- Result capture: fir_y_vld=1 in START or WAIT -> m_data<=fir_y, m_valid<=1, sample_cnt+1 on the next edge. fir_y_vld is ignored in IDLE and ERR.
- Output register: m_valid clears on m_ready when no capture occurs that cycle. Capture and drain in the same cycle leave m_valid=1 with the new data.
- Launch only when the output register is empty or draining, so a capture never overwrites unconsumed data.
- Watchdog: counter resets on entry to START and increments each cycle in START/WAIT. When it reaches TIMEOUT -> ERR.
- ERR: err_timeout=1, fir_start=0, s_ready=0, m_valid unchanged (may still drain). Exit only by ap_rst.
- busy = (state != IDLE).

Latency:
- Accepted sample to fir_start = 2 cycles when idle (FIFO write, then launch).
- Result appears 1 cycle after fir_y_vld.

Test Plan:
- Bench runs with fir_hls instantiated and m_ready=1.
  - Single sample x=0x00 -> exactly one result m_data=0x0000, sample_cnt=1, busy returns to 0.
  - Impulse x=1 followed by seven 0s -> 8 results equal to the C-model coefficients in order, sample_cnt=8.
- Backpressure: m_ready=0 while 6 samples are offered -> 1 result held, 4 samples queued, s_ready=0. Then m_ready=1 -> all 5 outputs emitted in order, none lost or duplicated.
- Stub core that holds fir_ready=0 for 10 cycles -> fir_start stays 1 and fir_x stays constant for those 10 cycles, and the pop happens only on the fir_ready cycle.
- Stub core that never asserts fir_ready -> err_timeout=1 exactly TIMEOUT=255 cycles after START entry; s_ready=0 and fir_start=0 afterwards, cleared only by ap_rst.
- ap_rst pulsed in WAIT with FIFO count=3 -> next cycle: m_valid=0, fir_start=0, sample_cnt=0, FIFO empty, s_ready=1 one cycle later. A subsequent sample x=0x00 yields 0x0000.
